// File: rtl/reg_file.sv
// reg_file: MIPS 32 x NB_DATA general-purpose register bank.
//   - writeback port (single write per cycle, gated by i_enable, r0 hard-wired to 0)
//   - two zero-latency combinational read ports (rs / rt)
//   - sequential dump engine streaming every register out, one beat per cycle
// Optional feature macro: REG_FILE_BYPASS_EN
//   defined   -> a same-cycle writeback to the addressed register is forwarded
//                to the rs / rt read ports (write-before-read)
//   undefined -> read ports return stored contents only
// The dump path always reads the stored array and is never bypassed.

module reg_file #(
   parameter int unsigned NB_DATA = 32,
   parameter int unsigned NB_REG  = 5
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_enable,
   input  logic               i_wb_reg_write,
   input  logic [NB_REG-1:0]  i_wb_selected_reg,
   input  logic [NB_DATA-1:0] i_wb_selected_data,
   input  logic [NB_REG-1:0]  i_rs_addr,
   input  logic [NB_REG-1:0]  i_rt_addr,
   output logic [NB_DATA-1:0] o_rs_data,
   output logic [NB_DATA-1:0] o_rt_data,
   input  logic               i_dbg_dump_start,
   output logic               o_dbg_busy,
   output logic               o_dbg_valid,
   output logic [NB_REG-1:0]  o_dbg_index,
   output logic [NB_DATA-1:0] o_dbg_data,
   output logic               o_dbg_last
);

   localparam int unsigned DEPTH    = 2 ** NB_REG;
   localparam int unsigned LAST_IDX = DEPTH - 1;

   typedef enum logic {
      IDLE = 1'b0,
      DUMP = 1'b1
   } state_t;

   // Register storage; entry 0 is never written so it stays at 0.
   logic [NB_DATA-1:0] regs [DEPTH];

   state_t             state;
   state_t             state_next;
   logic [NB_REG-1:0]  idx;
   logic [NB_REG-1:0]  idx_next;

   logic               dbg_valid_next;
   logic               dbg_last_next;
   logic [NB_REG-1:0]  dbg_index_next;
   logic [NB_DATA-1:0] dbg_data_next;

   logic               wr_en_c;
   logic               idx_is_last_c;

   assign wr_en_c       = i_enable & i_wb_reg_write & (i_wb_selected_reg != '0);
   assign idx_is_last_c = (idx == NB_REG'(LAST_IDX));

   // Register array: synchronous clear, gated writeback, r0 protected.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en_c) begin
         regs[i_wb_selected_reg] <= i_wb_selected_data;
      end
   end

   // Read port A: address 0 forced to 0, optional same-cycle forwarding.
   always_comb begin
      o_rs_data = '0;
      if (i_rs_addr != '0) begin
         o_rs_data = regs[i_rs_addr];
      end
`ifdef REG_FILE_BYPASS_EN
      if (wr_en_c && (i_wb_selected_reg == i_rs_addr)) begin
         o_rs_data = i_wb_selected_data;
      end
`endif
   end

   // Read port B: same structure as port A.
   always_comb begin
      o_rt_data = '0;
      if (i_rt_addr != '0) begin
         o_rt_data = regs[i_rt_addr];
      end
`ifdef REG_FILE_BYPASS_EN
      if (wr_en_c && (i_wb_selected_reg == i_rt_addr)) begin
         o_rt_data = i_wb_selected_data;
      end
`endif
   end

   // Dump FSM state, walk index and registered beat outputs.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state       <= IDLE;
         idx         <= '0;
         o_dbg_valid <= 1'b0;
         o_dbg_last  <= 1'b0;
         o_dbg_index <= '0;
         o_dbg_data  <= '0;
      end else begin
         state       <= state_next;
         idx         <= idx_next;
         o_dbg_valid <= dbg_valid_next;
         o_dbg_last  <= dbg_last_next;
         o_dbg_index <= dbg_index_next;
         o_dbg_data  <= dbg_data_next;
      end
   end

   // Dump FSM next-state and beat generation; start is ignored while dumping.
   always_comb begin
      state_next     = state;
      idx_next       = idx;
      dbg_valid_next = 1'b0;
      dbg_last_next  = 1'b0;
      dbg_index_next = o_dbg_index;
      dbg_data_next  = o_dbg_data;

      case (state)
         IDLE: begin
            if (i_dbg_dump_start) begin
               state_next = DUMP;
               idx_next   = '0;
            end
         end
         DUMP: begin
            // Array value sampled before this edge's write lands.
            dbg_valid_next = 1'b1;
            dbg_index_next = idx;
            dbg_data_next  = regs[idx];
            dbg_last_next  = idx_is_last_c;
            idx_next       = idx + NB_REG'(1);
            if (idx_is_last_c) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign o_dbg_busy = (state == DUMP);

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file (both bypass builds supported).

module tb_reg_file;

   localparam int unsigned NB_DATA = 32;
   localparam int unsigned NB_REG  = 5;

   logic               clk;
   logic               reset;
   logic               enable;
   logic               wb_reg_write;
   logic [NB_REG-1:0]  wb_selected_reg;
   logic [NB_DATA-1:0] wb_selected_data;
   logic [NB_REG-1:0]  rs_addr;
   logic [NB_REG-1:0]  rt_addr;
   logic [NB_DATA-1:0] rs_data;
   logic [NB_DATA-1:0] rt_data;
   logic               dump_start;
   logic               dbg_busy;
   logic               dbg_valid;
   logic [NB_REG-1:0]  dbg_index;
   logic [NB_DATA-1:0] dbg_data;
   logic               dbg_last;

   int n_checks = 0;
   int n_errors = 0;

   logic [NB_DATA-1:0] expect_regs [32];
   logic [NB_DATA-1:0] bypass_val;

   reg_file #(
      .NB_DATA (NB_DATA),
      .NB_REG  (NB_REG)
   ) dut (
      .i_clock            (clk),
      .i_reset            (reset),
      .i_enable           (enable),
      .i_wb_reg_write     (wb_reg_write),
      .i_wb_selected_reg  (wb_selected_reg),
      .i_wb_selected_data (wb_selected_data),
      .i_rs_addr          (rs_addr),
      .i_rt_addr          (rt_addr),
      .o_rs_data          (rs_data),
      .o_rt_data          (rt_data),
      .i_dbg_dump_start   (dump_start),
      .o_dbg_busy         (dbg_busy),
      .o_dbg_valid        (dbg_valid),
      .o_dbg_index        (dbg_index),
      .o_dbg_data         (dbg_data),
      .o_dbg_last         (dbg_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle 1 time unit before driving / sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [4:0] sel, input logic [31:0] data);
      wb_reg_write     = 1'b1;
      wb_selected_reg  = sel;
      wb_selected_data = data;
      step();
      wb_reg_write     = 1'b0;
   endtask

   // Start a dump and check every beat; optional re-pulse of start and abort by reset.
   task automatic run_dump(input string name, input int repulse_at, input int abort_at);
      bit aborted;
      aborted    = 1'b0;
      dump_start = 1'b1;
      step();
      dump_start = 1'b0;
      #1;
      check($sformatf("%s_busy_start", name), 32'(dbg_busy), 32'd1);
      check($sformatf("%s_valid_pre", name), 32'(dbg_valid), 32'd0);
      for (int k = 0; k < 32; k++) begin
         if (!aborted) begin
            step();
            dump_start = 1'b0;
            check($sformatf("%s_valid_%0d", name, k), 32'(dbg_valid), 32'd1);
            check($sformatf("%s_index_%0d", name, k), 32'(dbg_index), 32'(k));
            check($sformatf("%s_data_%0d", name, k), dbg_data, expect_regs[k]);
            check($sformatf("%s_last_%0d", name, k), 32'(dbg_last), (k == 31) ? 32'd1 : 32'd0);
            check($sformatf("%s_busy_%0d", name, k), 32'(dbg_busy), (k == 31) ? 32'd0 : 32'd1);
            if (k == abort_at) begin
               reset = 1'b1;
               step();
               reset = 1'b0;
               check($sformatf("%s_abort_valid", name), 32'(dbg_valid), 32'd0);
               check($sformatf("%s_abort_busy", name), 32'(dbg_busy), 32'd0);
               check($sformatf("%s_abort_last", name), 32'(dbg_last), 32'd0);
               aborted = 1'b1;
            end else if (k == repulse_at) begin
               dump_start = 1'b1;
            end
         end
      end
      if (!aborted) begin
         step();
         check($sformatf("%s_valid_post", name), 32'(dbg_valid), 32'd0);
         check($sformatf("%s_last_post", name), 32'(dbg_last), 32'd0);
         check($sformatf("%s_busy_post", name), 32'(dbg_busy), 32'd0);
         step();
         check($sformatf("%s_no_restart", name), 32'(dbg_valid), 32'd0);
      end
   endtask

   initial begin
`ifdef REG_FILE_BYPASS_EN
      bypass_val = 32'hDEAD_BEEF;
`else
      bypass_val = 32'h0000_0000;
`endif
      reset            = 1'b1;
      enable           = 1'b1;
      wb_reg_write     = 1'b0;
      wb_selected_reg  = '0;
      wb_selected_data = '0;
      rs_addr          = '0;
      rt_addr          = '0;
      dump_start       = 1'b0;
      for (int i = 0; i < 32; i++) expect_regs[i] = 32'h0;

      // Test 1: reset state and an all-zero dump.
      step();
      step();
      reset = 1'b0;
      rs_addr = 5'd5;
      rt_addr = 5'd31;
      #1;
      check("rst_valid", 32'(dbg_valid), 32'd0);
      check("rst_last", 32'(dbg_last), 32'd0);
      check("rst_busy", 32'(dbg_busy), 32'd0);
      check("rst_index", 32'(dbg_index), 32'd0);
      check("rst_data", dbg_data, 32'd0);
      check("rst_rs5", rs_data, 32'd0);
      check("rst_rt31", rt_data, 32'd0);
      run_dump("dump0", -1, -1);

      // Test 2: write r7 with same-cycle read.
      rs_addr          = 5'd7;
      rt_addr          = 5'd7;
      wb_reg_write     = 1'b1;
      wb_selected_reg  = 5'd7;
      wb_selected_data = 32'hDEAD_BEEF;
      #1;
      check("r7_same_cycle_rs", rs_data, bypass_val);
      check("r7_same_cycle_rt", rt_data, bypass_val);
      step();
      wb_reg_write = 1'b0;
      #1;
      check("r7_next_cycle_rs", rs_data, 32'hDEAD_BEEF);
      check("r7_next_cycle_rt", rt_data, 32'hDEAD_BEEF);

      // Test 3: r0 is read-only zero, even in the write cycle.
      rs_addr          = 5'd0;
      wb_reg_write     = 1'b1;
      wb_selected_reg  = 5'd0;
      wb_selected_data = 32'h0000_1234;
      #1;
      check("r0_same_cycle", rs_data, 32'd0);
      step();
      wb_reg_write = 1'b0;
      #1;
      check("r0_after_write", rs_data, 32'd0);

      // Test 4: enable gates writes.
      rs_addr = 5'd3;
      enable  = 1'b0;
      write_reg(5'd3, 32'h55);
      #1;
      check("r3_disabled", rs_data, 32'd0);
      enable = 1'b1;
      write_reg(5'd3, 32'h55);
      #1;
      check("r3_enabled", rs_data, 32'h55);

      // Test 5: load r1..r31 = n*0x11, dump with a start re-pulse at beat 4.
      for (int n = 1; n < 32; n++) begin
         write_reg(5'(n), 32'(n * 32'h11));
         expect_regs[n] = 32'(n * 32'h11);
      end
      rs_addr = 5'd31;
      rt_addr = 5'd16;
      #1;
      check("r31_loaded", rs_data, 32'h0000_020F);
      check("r16_loaded", rt_data, 32'h0000_0110);
      run_dump("dump1", 4, -1);

      // Test 6: reset during beat 10 aborts the dump and clears the bank.
      run_dump("dump2", -1, 10);
      for (int i = 0; i < 32; i++) expect_regs[i] = 32'h0;
      for (int i = 0; i < 32; i++) begin
         rs_addr = 5'(i);
         rt_addr = 5'(31 - i);
         #1;
         check($sformatf("clr_rs_%0d", i), rs_data, 32'd0);
         check($sformatf("clr_rt_%0d", 31 - i), rt_data, 32'd0);
      end
      run_dump("dump3", -1, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
